hls_deadlock_axis_stall_detector: RTL and testbench

HLS_DEADLOCK_AXIS_STALL_DETECTOR -- requirements
Module: hls_deadlock_axis_stall_detector

---
 rtl/hls_deadlock_axis_stall_detector.sv | 148 ++++++++++++++
 tb/tb_hls_deadlock_axis_stall_detector.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/hls_deadlock_axis_stall_detector.sv
// hls_deadlock_axis_stall_detector
//
// Watches a set of AXIS channel taps and flags a channel as blocked once it
// has been stalled for STALL_THRESH consecutive cycles. A channel is stalled
// when exactly one side of its handshake is up (valid without ready, or ready
// without valid) while the owning instance is not idle. Newly blocked
// channels produce a timestamped report record on a valid/ready output.
//
// Handshake (report output): a record is transferred on a rising clock edge
// where rpt_valid and rpt_ready are both 1. Once rpt_valid is raised it stays
// high, and rpt_mask/rpt_time stay stable, until that transfer happens.
// rpt_ovf may go from 0 to 1 while pending, to note lost block events.
//
// Ports:
//   clock, reset       rising-edge clock; synchronous active-high reset
//   ch_tvalid/tready   per-channel AXIS handshake taps
//   inst_idle          per-channel idle flag of the owning instance
//   axis_block_sigs    per-channel blocked flag (registered)
//   rpt_valid/ready    report record handshake
//   rpt_mask           blocked-channel snapshot at capture time
//   rpt_time           free-running timestamp at capture time
//   rpt_ovf            further block events arrived while record pending
//   dbg_state          report FSM state (0 = EMPTY, 1 = PENDING)
module hls_deadlock_axis_stall_detector #(
   parameter int NUM_CH       = 7,
   parameter int STALL_THRESH = 1024,
   parameter int CNT_W        = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [NUM_CH-1:0] ch_tvalid,
   input  logic [NUM_CH-1:0] ch_tready,
   input  logic [NUM_CH-1:0] inst_idle,
   output logic [NUM_CH-1:0] axis_block_sigs,
   output logic              rpt_valid,
   input  logic              rpt_ready,
   output logic [NUM_CH-1:0] rpt_mask,
   output logic [31:0]       rpt_time,
   output logic              rpt_ovf,
   output logic              dbg_state
);

   localparam logic [CNT_W-1:0] THRESH = CNT_W'(STALL_THRESH);

   typedef enum logic {
      EMPTY   = 1'b0,
      PENDING = 1'b1
   } rpt_state_t;

   logic [NUM_CH-1:0] stall;
   logic [CNT_W-1:0]  cnt_q [NUM_CH];
   logic [CNT_W-1:0]  cnt_d [NUM_CH];
   logic [31:0]       timestamp_q, timestamp_d;
   logic [NUM_CH-1:0] prev_block_q;
   logic [NUM_CH-1:0] rise;
   rpt_state_t        state_q, state_d;
   logic [NUM_CH-1:0] rpt_mask_q, rpt_mask_d;
   logic [31:0]       rpt_time_q, rpt_time_d;
   logic              rpt_ovf_q, rpt_ovf_d;

   // Per-channel stall counters: count up while stalled and hold at the
   // threshold; any non-stall cycle (transfer, quiet or idle) restarts them.
   always_comb begin
      stall = (ch_tvalid ^ ch_tready) & ~inst_idle;
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_d[i] = '0;
         if (stall[i]) begin
            cnt_d[i] = (cnt_q[i] == THRESH) ? cnt_q[i] : cnt_q[i] + 1'b1;
         end
      end
   end

   // Block flags decode only the counter registers, so there is no path
   // from the channel taps to this output within a cycle.
   always_comb begin
      axis_block_sigs = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         axis_block_sigs[i] = (cnt_q[i] == THRESH);
      end
   end

   assign timestamp_d = timestamp_q + 32'd1;
   assign rise        = axis_block_sigs & ~prev_block_q;

   // Report FSM next-state. An acceptance coinciding with a new rise
   // replaces the record directly so no event is dropped.
   always_comb begin
      state_d    = state_q;
      rpt_mask_d = rpt_mask_q;
      rpt_time_d = rpt_time_q;
      rpt_ovf_d  = rpt_ovf_q;
      case (state_q)
         EMPTY: begin
            if (|rise) begin
               rpt_mask_d = axis_block_sigs;
               rpt_time_d = timestamp_q;
               rpt_ovf_d  = 1'b0;
               state_d    = PENDING;
            end
         end
         PENDING: begin
            if (rpt_ready) begin
               if (|rise) begin
                  rpt_mask_d = axis_block_sigs;
                  rpt_time_d = timestamp_q;
                  rpt_ovf_d  = 1'b0;
               end else begin
                  state_d = EMPTY;
               end
            end else if (|rise) begin
               rpt_ovf_d = 1'b1;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= '0;
         end
         timestamp_q  <= '0;
         prev_block_q <= '0;
         state_q      <= EMPTY;
         rpt_mask_q   <= '0;
         rpt_time_q   <= '0;
         rpt_ovf_q    <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         timestamp_q  <= timestamp_d;
         prev_block_q <= axis_block_sigs;
         state_q      <= state_d;
         rpt_mask_q   <= rpt_mask_d;
         rpt_time_q   <= rpt_time_d;
         rpt_ovf_q    <= rpt_ovf_d;
      end
   end

   assign rpt_valid = (state_q == PENDING);
   assign rpt_mask  = rpt_mask_q;
   assign rpt_time  = rpt_time_q;
   assign rpt_ovf   = rpt_ovf_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_hls_deadlock_axis_stall_detector.sv
// Directed bench for hls_deadlock_axis_stall_detector with NUM_CH=7 and
// STALL_THRESH=4. Inputs change and outputs are sampled 1ns after each
// rising edge. ts_m models the free-running timestamp (reset to 0 at a
// reset edge, +1 on every other edge).
module tb_hls_deadlock_axis_stall_detector;

   localparam int NCH = 7;

   logic           clock;
   logic           reset;
   logic [NCH-1:0] ch_tvalid;
   logic [NCH-1:0] ch_tready;
   logic [NCH-1:0] inst_idle;
   logic [NCH-1:0] axis_block_sigs;
   logic           rpt_valid;
   logic           rpt_ready;
   logic [NCH-1:0] rpt_mask;
   logic [31:0]    rpt_time;
   logic           rpt_ovf;
   logic           dbg_state;

   logic [31:0]    ts_m;
   logic [31:0]    t_exp;
   int             n_checks;
   int             n_pass;

   hls_deadlock_axis_stall_detector #(
      .NUM_CH      (NCH),
      .STALL_THRESH(4),
      .CNT_W       (16)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .ch_tvalid      (ch_tvalid),
      .ch_tready      (ch_tready),
      .inst_idle      (inst_idle),
      .axis_block_sigs(axis_block_sigs),
      .rpt_valid      (rpt_valid),
      .rpt_ready      (rpt_ready),
      .rpt_mask       (rpt_mask),
      .rpt_time       (rpt_time),
      .rpt_ovf        (rpt_ovf),
      .dbg_state      (dbg_state)
   );

   // Clock and reset-aware timestamp model
   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (reset) ts_m <= 32'd0;
      else       ts_m <= ts_m + 32'd1;
   end

   // Driver helpers
   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      t_exp     = 32'd0;
      reset     = 1'b1;
      ch_tvalid = '0;
      ch_tready = '0;
      inst_idle = '0;
      rpt_ready = 1'b0;

      // Reset state
      step(2);
      reset = 1'b0;
      check("rst_block", 32'(axis_block_sigs), 32'h00);
      check("rst_valid", 32'(rpt_valid), 32'd0);
      check("rst_state", 32'(dbg_state), 32'd0);

      // ch0 valid without ready: blocked after the 4th stalled edge
      ch_tvalid = 7'h01;
      step(3);
      check("ch0_block_at3", 32'(axis_block_sigs), 32'h00);
      step(1);
      check("ch0_block_at4", 32'(axis_block_sigs), 32'h01);
      check("ch0_valid_before_capture", 32'(rpt_valid), 32'd0);
      t_exp = ts_m;
      step(1);
      check("ch0_rpt_valid", 32'(rpt_valid), 32'd1);
      check("ch0_rpt_mask", 32'(rpt_mask), 32'h01);
      check("ch0_rpt_time", rpt_time, t_exp);
      check("ch0_rpt_ovf", 32'(rpt_ovf), 32'd0);
      check("ch0_block_held", 32'(axis_block_sigs), 32'h01);
      // Drain: stop stalling and accept in the same edge
      ch_tvalid = '0;
      rpt_ready = 1'b1;
      step(1);
      check("ch0_accept_valid", 32'(rpt_valid), 32'd0);
      check("ch0_unblock", 32'(axis_block_sigs), 32'h00);
      rpt_ready = 1'b0;

      // ch2: 3 stalls, a transfer, 3 stalls -> never blocks
      ch_tvalid = 7'h04;
      step(3);
      ch_tready = 7'h04;
      step(1);
      check("ch2_after_xfer_block", 32'(axis_block_sigs), 32'h00);
      ch_tready = '0;
      step(3);
      check("ch2_block", 32'(axis_block_sigs), 32'h00);
      check("ch2_no_rpt", 32'(rpt_valid), 32'd0);
      ch_tvalid = '0;
      step(1);

      // ch3 stalled but its instance is idle for 100 cycles
      inst_idle = 7'h08;
      ch_tvalid = 7'h08;
      step(100);
      check("ch3_idle_block", 32'(axis_block_sigs), 32'h00);
      check("ch3_idle_no_rpt", 32'(rpt_valid), 32'd0);
      // Leaving idle with the stall still present starts the count from 0
      inst_idle = '0;
      step(3);
      check("ch3_count_from_zero", 32'(axis_block_sigs), 32'h00);
      ch_tvalid = '0;
      step(1);

      // ch1 blocks with consumer stalled, ch4 blocks 5 cycles later -> ovf
      ch_tvalid = 7'h02;
      step(4);
      check("ch1_block", 32'(axis_block_sigs), 32'h02);
      t_exp = ts_m;
      step(1);
      check("ch1_rpt_valid", 32'(rpt_valid), 32'd1);
      ch_tvalid = 7'h12;
      step(4);
      check("ch14_block", 32'(axis_block_sigs), 32'h12);
      check("ch1_ovf_not_yet", 32'(rpt_ovf), 32'd0);
      step(1);
      check("ch1_ovf", 32'(rpt_ovf), 32'd1);
      check("ch1_mask_held", 32'(rpt_mask), 32'h02);
      check("ch1_time_held", rpt_time, t_exp);
      check("ch1_valid_held", 32'(rpt_valid), 32'd1);
      rpt_ready = 1'b1;
      step(1);
      check("ch1_accept_empty", 32'(rpt_valid), 32'd0);
      step(1);
      check("ch1_stays_empty", 32'(rpt_valid), 32'd0);
      rpt_ready = 1'b0;
      ch_tvalid = '0;
      step(1);
      check("ch14_unblock", 32'(axis_block_sigs), 32'h00);

      // ch5 and ch6 rise together -> one record with both
      ch_tready = 7'h60;
      step(4);
      check("ch56_block", 32'(axis_block_sigs), 32'h60);
      t_exp = ts_m;
      step(1);
      check("ch56_rpt_mask", 32'(rpt_mask), 32'h60);
      check("ch56_rpt_ovf", 32'(rpt_ovf), 32'd0);
      check("ch56_rpt_time", rpt_time, t_exp);
      // ch0 rise lands on the same edge as the acceptance
      ch_tvalid = 7'h01;
      step(4);
      check("ch056_block", 32'(axis_block_sigs), 32'h61);
      rpt_ready = 1'b1;
      t_exp = ts_m;
      step(1);
      rpt_ready = 1'b0;
      check("coinc_valid", 32'(rpt_valid), 32'd1);
      check("coinc_mask", 32'(rpt_mask), 32'h61);
      check("coinc_time", rpt_time, t_exp);
      check("coinc_ovf", 32'(rpt_ovf), 32'd0);

      // Reset while blocked and record pending; stalls continue after it
      reset = 1'b1;
      step(1);
      check("mid_rst_block", 32'(axis_block_sigs), 32'h00);
      check("mid_rst_valid", 32'(rpt_valid), 32'd0);
      reset = 1'b0;
      step(3);
      check("post_rst_block_at3", 32'(axis_block_sigs), 32'h00);
      step(1);
      check("post_rst_block_at4", 32'(axis_block_sigs), 32'h61);
      step(1);
      check("post_rst_valid", 32'(rpt_valid), 32'd1);
      check("post_rst_mask", 32'(rpt_mask), 32'h61);
      check("post_rst_time", rpt_time, 32'd4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
